// File: rtl/mem_pkg.sv
// Shared types and constants for the slowmem arbiter: word width, memory
// latency, arbiter state encoding and the default requester map.
package mem_pkg;

    localparam int WORD     = 16;
    localparam int MEMDELAY = 4;

    localparam int NREQ_DEF = 4;
    localparam int IC0      = 0;
    localparam int IC1      = 1;
    localparam int DC0      = 2;
    localparam int DC1      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester strictly after ptr,
// wrapping around; returns a one-hot grant and an any-valid flag.
module rr_picker
    import mem_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = ptr_bits(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            any
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [NREQ-1:0] above_ptr;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick_src;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign above_ptr[gi] = (gi > int'(ptr));
        end
    endgenerate

    // Requesters above the pointer win first; otherwise wrap to the lowest index.
    assign hi_req   = valid & above_ptr;
    assign pick_src = (|hi_req) ? hi_req : valid;
    assign grant    = pick_src & (~pick_src + ONE);
    assign any      = |valid;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slowmem port between NREQ cache requesters,
// one transaction in flight. Optional WAIT timeout: define MEMARB_TIMEOUT_EN.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int AW      = 16,
    parameter int DW      = WORD,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_rnotw,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_done,
    output logic                 req_err,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      grant,
    output logic                 mem_strobe,
    output logic                 mem_rnotw,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic                 mem_mfc,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int PW = ptr_bits(NREQ);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic            strobe_q, strobe_d;
    logic            rnotw_q, rnotw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0] pick_oh;
    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic            sel_rnotw;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic            unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .valid (req_valid),
        .ptr   (rr_q),
        .grant (pick_oh),
        .any   (pick_any)
    );

    // Encode the one-hot pick and steer that requester's command fields.
    always_comb begin
        pick_idx  = '0;
        sel_rnotw = 1'b1;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx  = PW'(i);
                sel_rnotw = req_rnotw[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        strobe_d = 1'b0;
        rnotw_d  = rnotw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef MEMARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d  = pick_oh;
                    gidx_d   = pick_idx;
                    rnotw_d  = sel_rnotw;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    strobe_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rr_d = gidx_q;
                if (rnotw_q) begin
                    state_d = WAIT;
`ifdef MEMARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    // slowmem commits the write on this edge; nothing to wait for.
                    done_d  = grant_q;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (mem_mfc) begin
                    rdata_d = mem_rdata;
                    done_d  = grant_q;
                    state_d = RESP;
                end
`ifdef MEMARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    done_d  = grant_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            rr_q     <= PW'(NREQ - 1);
            gidx_q   <= '0;
            strobe_q <= 1'b0;
            rnotw_q  <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            strobe_q <= strobe_d;
            rnotw_q  <= rnotw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign req_err = err_q;
`else
    assign req_err = 1'b0;
`endif

    assign req_done   = done_q;
    assign rdata      = rdata_q;
    assign grant      = grant_q;
    assign mem_strobe = strobe_q;
    assign mem_rnotw  = rnotw_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural slowmem (MEMDELAY latency).
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int TMO  = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_rnotw = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_done;
    logic                 req_err;
    logic [DW-1:0]        rdata;
    logic [NREQ-1:0]      grant;
    logic                 mem_strobe;
    logic                 mem_rnotw;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_mfc = 1'b0;
    logic [DW-1:0]        mem_rdata = '0;

    mem_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rnotw  (req_rnotw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_done   (req_done),
        .req_err    (req_err),
        .rdata      (rdata),
        .grant      (grant),
        .mem_strobe (mem_strobe),
        .mem_rnotw  (mem_rnotw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mfc    (mem_mfc),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back a fixed pattern; 0x0010 yields 0xBEEF.
    function automatic logic [15:0] seed(input logic [7:0] a);
        return {8'h00, a} ^ 16'hBEFF;
    endfunction

    // ---------------- slowmem model ----------------
    logic [DW-1:0] mem [256];
    bit            mem_wr [256];
    int            rd_cnt = 0;
    logic [7:0]    rd_a = '0;
    bit            suppress_mfc = 1'b0;

    always @(posedge clk) begin
        mem_mfc <= 1'b0;
        if (mem_strobe && !mem_rnotw) begin
            mem[mem_addr[7:0]]    <= mem_wdata;
            mem_wr[mem_addr[7:0]] <= 1'b1;
        end
        if (mem_strobe && mem_rnotw) begin
            rd_cnt <= MEMDELAY - 1;
            rd_a   <= mem_addr[7:0];
        end else if (rd_cnt > 0) begin
            rd_cnt <= rd_cnt - 1;
            if (rd_cnt == 1 && !suppress_mfc) begin
                mem_mfc   <= 1'b1;
                mem_rdata <= mem_wr[rd_a] ? mem[rd_a] : seed(rd_a);
            end
        end
    end

    // ---------------- monitor ----------------
    typedef struct packed {
        logic [NREQ-1:0] mask;
        logic [DW-1:0]   data;
        logic            err;
        logic [31:0]     cyc;
    } obs_t;

    typedef struct packed {
        logic [NREQ-1:0] mask;
        logic [DW-1:0]   data;
        logic            err;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    int   done_cnt [NREQ];
    int   strobe_cnt = 0;
    int   strobe_cyc = 0;
    int   last_done_cyc = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        obs_t o;
        if (mem_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
        end
        if (req_done != '0) begin
            o.mask = req_done;
            o.data = rdata;
            o.err  = req_err;
            o.cyc  = cyc;
            obs_q.push_back(o);
            last_done_cyc = cyc;
            for (int i = 0; i < NREQ; i++)
                if (req_done[i]) done_cnt[i] = done_cnt[i] + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] ref_mem [256];
    bit            ref_wr [256];

    task automatic req_set(input int i, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rnotw[i]           = rnw;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
        req_valid[i]           = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic rnw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic err);
        exp_t e;
        e.mask = NREQ'(1) << i;
        e.err  = err;
        if (err) begin
            e.data = '0;
        end else if (!rnw) begin
            ref_mem[a[7:0]] = d;
            ref_wr[a[7:0]]  = 1'b1;
            e.data = '0;
        end else begin
            e.data = ref_wr[a[7:0]] ? ref_mem[a[7:0]] : seed(a[7:0]);
        end
        exp_q.push_back(e);
    endtask

    // Requester side: drop each valid on the edge ending its done pulse.
    task automatic run_txns(input int n, input bit keep, input int budget);
        int seen [NREQ];
        int got;
        got = 0;
        for (int i = 0; i < NREQ; i++) seen[i] = done_cnt[i];
        for (int c = 0; c < budget && got < n; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (done_cnt[i] != seen[i]) begin
                    got     = got + done_cnt[i] - seen[i];
                    seen[i] = done_cnt[i];
                    if (!keep) req_valid[i] = 1'b0;
                end
            end
            if (got >= n) req_valid = '0;
        end
        req_valid = '0;
        check_val("txn_count", got, n);
    endtask

    task automatic score(input string tag);
        exp_t e;
        obs_t o;
        check_val({tag, "_ndone"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            $display("[TB] txn %s done=%b rdata=0x%04h err=%b cyc=%0d", tag, o.mask, o.data, o.err, o.cyc);
            check_val({tag, "_who"},   o.mask, e.mask);
            check_val({tag, "_rdata"}, o.data, e.data);
            check_val({tag, "_err"},   o.err,  e.err);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got sim time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int sc0;

        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_grant",  grant, 0);
        check_val("rst_done",   req_done, 0);
        check_val("rst_strobe", mem_strobe, 0);
        check_val("rst_rnotw",  mem_rnotw, 1);
        check_val("rst_addr",   mem_addr, 0);
        check_val("rst_rdata",  rdata, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a read; the late mfc lands in IDLE.
        req_set(1, 1'b1, 16'h0020, '0);
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_grant_wait", grant, 4'b0010);
        reset     = 1'b0;
        req_valid = '0;
        #1;
        check_val("mid_grant_async", grant, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_val("mid_no_done", obs_q.size(), 0);
        check_val("mid_grant_idle", grant, 0);
        req_set(0, 1'b1, 16'h0021, '0);
        req_set(1, 1'b1, 16'h0022, '0);
        push_exp(0, 1'b1, 16'h0021, '0, 1'b0);
        push_exp(1, 1'b1, 16'h0022, '0, 1'b0);
        run_txns(2, 1'b0, 60);
        score("after_rst");

        // Single read with latency checks.
        sc0 = strobe_cnt;
        t0  = cyc;
        req_set(0, 1'b1, 16'h0010, '0);
        push_exp(0, 1'b1, 16'h0010, '0, 1'b0);
        run_txns(1, 1'b0, 40);
        check_val("rd_strobes",   strobe_cnt - sc0, 1);
        check_val("rd_strobe_cyc", strobe_cyc - t0, 1);
        check_val("rd_done_cyc",   last_done_cyc - t0, 6);
        score("single_rd");

        // Write then read back through requester 2.
        sc0 = strobe_cnt;
        t0  = cyc;
        req_set(DC0, 1'b0, 16'h0042, 16'h1234);
        push_exp(DC0, 1'b0, 16'h0042, 16'h1234, 1'b0);
        run_txns(1, 1'b0, 40);
        check_val("wr_strobe_cyc", strobe_cyc - t0, 1);
        check_val("wr_done_cyc",   last_done_cyc - t0, 2);
        score("write");
        req_set(DC0, 1'b1, 16'h0042, '0);
        push_exp(DC0, 1'b1, 16'h0042, '0, 1'b0);
        run_txns(1, 1'b0, 40);
        check_val("wr_strobes", strobe_cnt - sc0, 2);
        score("readback");

        // All four requesters at once right after reset.
        pulse_reset();
        sc0 = strobe_cnt;
        for (int i = 0; i < NREQ; i++) req_set(i, 1'b1, AW'(16'h0030 + i), '0);
        for (int i = 0; i < NREQ; i++) push_exp(i, 1'b1, AW'(16'h0030 + i), '0, 1'b0);
        run_txns(NREQ, 1'b0, 200);
        check_val("sim_strobes", strobe_cnt - sc0, NREQ);
        score("simul");

        // Two requesters held valid: strict alternation.
        pulse_reset();
        sc0 = strobe_cnt;
        req_set(IC0, 1'b1, 16'h0050, '0);
        req_set(DC1, 1'b1, 16'h0053, '0);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push_exp(IC0, 1'b1, 16'h0050, '0, 1'b0);
            else            push_exp(DC1, 1'b1, 16'h0053, '0, 1'b0);
        end
        run_txns(8, 1'b1, 400);
        check_val("starve_strobes", strobe_cnt - sc0, 8);
        score("starve");

`ifdef MEMARB_TIMEOUT_EN
        // mfc withheld: abort after TIMEOUT cycles in WAIT.
        suppress_mfc = 1'b1;
        t0 = cyc;
        req_set(IC1, 1'b1, 16'h0060, '0);
        push_exp(IC1, 1'b1, 16'h0060, '0, 1'b1);
        run_txns(1, 1'b0, 100);
        check_val("tmo_done_cyc", last_done_cyc - t0, 2 + TMO);
        score("timeout");
        @(posedge clk); #1;
        check_val("tmo_grant_idle", grant, 0);
        repeat (4) @(posedge clk);
        #1;
        suppress_mfc = 1'b0;
        req_set(IC1, 1'b1, 16'h0061, '0);
        push_exp(IC1, 1'b1, 16'h0061, '0, 1'b0);
        run_txns(1, 1'b0, 100);
        score("tmo_recover");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
